// File: rtl/cim_pkg.sv
// Shared CIM constants, accumulator FSM encoding and the per-lane
// shift/saturate helper used by the PSUM accumulator.
package cim_pkg;

  localparam int unsigned N_COL   = 8;
  localparam int unsigned PSUM_W  = 14;
  localparam int unsigned ACC_W   = 18;
  localparam int unsigned ACT_W   = 4;
  localparam int unsigned OUT_W   = ACT_W;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned SHIFT_W = 5;

  // Shift amounts at or beyond ACC_W clear the lane.
  localparam logic [SHIFT_W-1:0] SHIFT_CLR = SHIFT_W'(ACC_W);
  localparam logic [ACC_W-1:0]   ACT_MAX   = ACC_W'((1 << ACT_W) - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } psum_acc_state_t;

  // Unsigned right shift followed by clamp to the activation range.
  function automatic logic [ACT_W-1:0] shift_sat(input logic [ACC_W-1:0]   sum,
                                                 input logic [SHIFT_W-1:0] sh);
    logic [ACC_W-1:0] s;
    s = (sh >= SHIFT_CLR) ? '0 : (sum >> sh);
    return (s > ACT_MAX) ? '1 : s[ACT_W-1:0];
  endfunction

endpackage

// File: rtl/psum_lane.sv
// One accumulator lane: ACC_W running sum with load/add control and the
// combinational shift/saturate of the post-add value.
module psum_lane
  import cim_pkg::*;
(
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               beat_i,
  input  logic               first_i,
  input  logic [PSUM_W-1:0]  psum_i,
  input  logic [SHIFT_W-1:0] shift_i,
  output logic [ACT_W-1:0]   act_o
);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] psum_ext;
  logic [ACC_W-1:0] sum_nxt;

  // Post-add sum: first beat loads, later beats add; activation taken from it.
  always_comb begin
    psum_ext = {{(ACC_W-PSUM_W){1'b0}}, psum_i};
    sum_nxt  = first_i ? psum_ext : (acc_q + psum_ext);
    acc_d    = beat_i ? sum_nxt : acc_q;
    act_o    = shift_sat(sum_nxt, shift_i);
  end

  // Accumulator register.
  always_ff @(posedge clk_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

endmodule

// File: rtl/psum_accumulator.sv
// PSUM accumulator: sums Macro PSUM vectors over 1..16 tiles, then shifts
// and saturates each lane to a 4b activation with valid/ready on both sides.
module psum_accumulator
  import cim_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [CNT_W-1:0]         num_tiles,
  input  logic [SHIFT_W-1:0]       shift,
  input  logic                     psum_valid,
  input  logic [N_COL*PSUM_W-1:0]  psum_in,
  output logic                     psum_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [N_COL*OUT_W-1:0]   out_data,
  output logic                     busy
);

  psum_acc_state_t           state_q, state_d;
  logic [CNT_W-1:0]          cnt_q, cnt_d;
  logic [CNT_W-1:0]          ntiles_q, ntiles_d;
  logic [SHIFT_W-1:0]        shift_q, shift_d;
  logic [N_COL*OUT_W-1:0]    out_data_q, out_data_d;
  logic [N_COL*OUT_W-1:0]    lane_act;
  logic                      beat;
  logic                      first;
  logic                      last;

  assign beat  = psum_valid && (state_q == ACCUM);
  assign first = (cnt_q == '0);
  assign last  = (cnt_q == ntiles_q);

  for (genvar k = 0; k < N_COL; k++) begin : g_lane
    psum_lane u_lane (
      .clk_i   (clk),
      .rst_i   (rst),
      .beat_i  (beat),
      .first_i (first),
      .psum_i  (psum_in[k*PSUM_W +: PSUM_W]),
      .shift_i (shift_q),
      .act_o   (lane_act[k*OUT_W +: OUT_W])
    );
  end

  // Next-state, tile counting, config latch and output capture.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ntiles_d   = ntiles_q;
    shift_d    = shift_q;
    out_data_d = out_data_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          ntiles_d = num_tiles;
          shift_d  = shift;
          cnt_d    = '0;
          state_d  = ACCUM;
        end
      end
      ACCUM: begin
        if (beat) begin
          if (last) begin
            state_d    = DRAIN;
            out_data_d = lane_act;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      DRAIN: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ntiles_q   <= '0;
      shift_q    <= '0;
      out_data_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ntiles_q   <= ntiles_d;
      shift_q    <= shift_d;
      out_data_q <= out_data_d;
    end
  end

  assign psum_ready = (state_q == ACCUM);
  assign out_valid  = (state_q == DRAIN);
  assign busy       = (state_q != IDLE);
  assign out_data   = out_data_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed + randomized bench for psum_accumulator with a sum-based reference model.
module tb_psum_accumulator;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [3:0]   num_tiles;
  logic [4:0]   shift;
  logic         psum_valid;
  logic [111:0] psum_in;
  logic         psum_ready;
  logic         out_valid;
  logic         out_ready;
  logic [31:0]  out_data;
  logic         busy;

  int checks = 0;
  int errors = 0;
  int unsigned sums [8];

  always #5 clk = ~clk;

  psum_accumulator dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_tiles  (num_tiles),
    .shift      (shift),
    .psum_valid (psum_valid),
    .psum_in    (psum_in),
    .psum_ready (psum_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .busy       (busy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] expected_out(input int sh);
    logic [31:0] r;
    int unsigned v;
    r = '0;
    for (int k = 0; k < 8; k++) begin
      v = sums[k] >> sh;
      if (v > 15) v = 15;
      r[k*4 +: 4] = v[3:0];
    end
    return r;
  endfunction

  // One complete job: start, nt+1 beats, drain with optional backpressure.
  task automatic run_job(input int nt, input int sh, input int val,
                         input bit rand_valid, input int hold, input bit stray_start);
    int beats;
    int cyc;
    int lane;
    bit v;
    logic [31:0] exp;
    @(negedge clk);
    start      = 1'b1;
    num_tiles  = 4'(nt);
    shift      = 5'(sh);
    psum_valid = 1'b1;
    psum_in    = {$urandom, $urandom, $urandom, $urandom};
    check("idle_ready", psum_ready, 0);
    check("idle_busy", busy, 0);
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 8; k++) sums[k] = 0;
    beats = 0;
    cyc   = 0;
    while (beats < nt + 1 && cyc < 300) begin
      check("accum_ready", psum_ready, 1);
      check("accum_no_out", out_valid, 0);
      v          = rand_valid ? 1'($urandom_range(0, 1)) : 1'b1;
      start      = stray_start ? 1'($urandom_range(0, 1)) : 1'b0;
      num_tiles  = 4'($urandom);
      shift      = 5'($urandom);
      out_ready  = 1'($urandom_range(0, 1));
      psum_valid = v;
      for (int k = 0; k < 8; k++) begin
        lane = (val < 0) ? int'($urandom_range(0, 16383)) : val;
        psum_in[k*14 +: 14] = 14'(lane);
        if (v) sums[k] += lane;
      end
      if (v) beats++;
      @(negedge clk);
      cyc++;
    end
    if (beats < nt + 1) check("accum_timeout", 32'(beats), 32'(nt + 1));
    psum_valid = 1'b0;
    start      = 1'b0;
    out_ready  = 1'b0;
    exp = expected_out(sh);
    check("latency_out_valid", out_valid, 1);
    check("out_data", out_data, exp);
    check("drain_busy", busy, 1);
    for (int i = 0; i < hold; i++) begin
      start     = 1'b1;
      num_tiles = 4'($urandom);
      shift     = 5'($urandom);
      @(negedge clk);
      check("drain_hold_valid", out_valid, 1);
      check("drain_stable", out_data, exp);
      check("drain_ready_low", psum_ready, 0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("drain_exit_valid", out_valid, 0);
    check("drain_exit_busy", busy, 0);
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_tiles  = '0;
    shift      = '0;
    psum_valid = 1'b0;
    psum_in    = '0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_psum_ready", psum_ready, 0);
    check("rst_busy", busy, 0);
    check("rst_out_data", out_data, 0);

    run_job(0, 0, 7, 1'b0, 0, 1'b0);
    run_job(15, 14, 14400, 1'b0, 2, 1'b1);
    run_job(1, 0, 100, 1'b0, 1, 1'b0);
    run_job(1, 31, 100, 1'b0, 0, 1'b0);
    run_job(2, 12, -1, 1'b1, 0, 1'b1);
    run_job(3, 13, -1, 1'b1, 5, 1'b0);

    // Abort after 2 of 4 beats.
    @(negedge clk);
    start     = 1'b1;
    num_tiles = 4'd3;
    shift     = 5'd0;
    @(negedge clk);
    start      = 1'b0;
    psum_valid = 1'b1;
    psum_in    = {8{14'd1000}};
    repeat (2) @(negedge clk);
    psum_valid = 1'b0;
    rst        = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_psum_ready", psum_ready, 0);
    @(negedge clk);
    check("abort_no_output", out_valid, 0);
    run_job(0, 0, 3, 1'b0, 0, 1'b0);

    for (int j = 0; j < 6; j++)
      run_job(int'($urandom_range(0, 15)), int'($urandom_range(0, 20)), -1, 1'b1,
              int'($urandom_range(0, 3)), 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
